// File: rtl/esc_deserializer_if.sv
// rtl/esc_deserializer_if.sv - LPDT bit stream in / assembled byte out bundle for esc_deserializer
// Optional RxByteCntEsc present when ESC_DESER_BYTECNT_EN is defined.
interface esc_deserializer_if #(
    parameter int BYTE_W = 8
);
    logic              EscDeserEn;
    logic              EscBit;
    logic              RxLpdtEsc;
    logic              LpFsmStop;
    logic [BYTE_W-1:0] RxDataEsc;
    logic              RxValidEsc;
    logic              RxPartialEsc;
    logic              RxActiveEsc;
`ifdef ESC_DESER_BYTECNT_EN
    logic [15:0]       RxByteCntEsc;

    modport master (
        output EscDeserEn, EscBit, RxLpdtEsc, LpFsmStop,
        input  RxDataEsc, RxValidEsc, RxPartialEsc, RxActiveEsc, RxByteCntEsc
    );
    modport slave (
        input  EscDeserEn, EscBit, RxLpdtEsc, LpFsmStop,
        output RxDataEsc, RxValidEsc, RxPartialEsc, RxActiveEsc, RxByteCntEsc
    );
`else
    modport master (
        output EscDeserEn, EscBit, RxLpdtEsc, LpFsmStop,
        input  RxDataEsc, RxValidEsc, RxPartialEsc, RxActiveEsc
    );
    modport slave (
        input  EscDeserEn, EscBit, RxLpdtEsc, LpFsmStop,
        output RxDataEsc, RxValidEsc, RxPartialEsc, RxActiveEsc
    );
`endif
endinterface

// File: rtl/esc_deserializer.sv
// rtl/esc_deserializer.sv - escape-mode LPDT byte assembler with partial-burst flag
// Define ESC_DESER_BYTECNT_EN to add the saturating per-burst byte counter RxByteCntEsc.
module esc_deserializer #(
    parameter int BYTE_W    = 8,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic RxClkEsc,
    input  logic RST,
    esc_deserializer_if.slave escIf
);
    localparam int             CNT_W    = $clog2(BYTE_W);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BYTE_W - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, FLUSH} state_t;

    state_t            state;
    logic [CNT_W-1:0]  bitCnt;
    logic [BYTE_W-1:0] shiftReg;

    logic              accept;
    logic              byteDone;
    logic [BYTE_W-1:0] shiftNext;
    logic [CNT_W-1:0]  cntNext;
    logic [CNT_W-1:0]  postCnt;

    assign accept = escIf.EscDeserEn & escIf.RxLpdtEsc;

    // Shift register only holds the byte in progress; IDLE keeps it zero so the
    // first capture uses the same shift path.
    always_comb begin
        shiftNext = shiftReg;
        if (LSB_FIRST)
            shiftNext = {escIf.EscBit, shiftReg[BYTE_W-1:1]};
        else
            shiftNext = {shiftReg[BYTE_W-2:0], escIf.EscBit};
        byteDone = accept && (bitCnt == LAST_CNT);
        cntNext  = byteDone ? '0 : bitCnt + CNT_W'(1);
        postCnt  = accept ? cntNext : bitCnt;
    end

    always_ff @(posedge RxClkEsc or posedge RST) begin
        if (RST) begin
            state                <= IDLE;
            bitCnt               <= '0;
            shiftReg             <= '0;
            escIf.RxDataEsc      <= '0;
            escIf.RxValidEsc     <= 1'b0;
            escIf.RxPartialEsc   <= 1'b0;
            escIf.RxActiveEsc    <= 1'b0;
`ifdef ESC_DESER_BYTECNT_EN
            escIf.RxByteCntEsc   <= '0;
`endif
        end else begin
            escIf.RxValidEsc   <= 1'b0;
            escIf.RxPartialEsc <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        shiftReg          <= shiftNext;
                        bitCnt            <= CNT_W'(1);
                        state             <= SHIFT;
                        escIf.RxActiveEsc <= 1'b1;
`ifdef ESC_DESER_BYTECNT_EN
                        escIf.RxByteCntEsc <= '0;
`endif
                    end
                end
                SHIFT: begin
                    if (accept) begin
                        shiftReg <= shiftNext;
                        bitCnt   <= cntNext;
                        if (byteDone) begin
                            escIf.RxDataEsc  <= shiftNext;
                            escIf.RxValidEsc <= 1'b1;
`ifdef ESC_DESER_BYTECNT_EN
                            if (escIf.RxByteCntEsc != 16'hFFFF)
                                escIf.RxByteCntEsc <= escIf.RxByteCntEsc + 16'd1;
`endif
                        end
                    end
                    // A bit arriving with stop is taken first; the partial flag sees the post-accept count.
                    if (!accept || escIf.LpFsmStop) begin
                        state              <= FLUSH;
                        escIf.RxActiveEsc  <= 1'b0;
                        escIf.RxPartialEsc <= (postCnt != '0);
                    end
                end
                FLUSH: begin
                    bitCnt   <= '0;
                    shiftReg <= '0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_esc_deserializer.sv
// tb/tb_esc_deserializer.sv - directed checks of esc_deserializer, LSB-first and MSB-first instances
module tb_esc_deserializer;
    logic clk = 1'b0;
    logic RST = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   validCnt = 0;
    int   partialCnt = 0;
    int   lastValidCyc = 0;
    int   prevValidCyc = 0;
    int   vSnap;
    int   pSnap;

    esc_deserializer_if #(.BYTE_W(8)) busA ();
    esc_deserializer_if #(.BYTE_W(8)) busB ();

    esc_deserializer #(.BYTE_W(8), .LSB_FIRST(1'b1)) dutA (
        .RxClkEsc (clk),
        .RST      (RST),
        .escIf    (busA)
    );
    esc_deserializer #(.BYTE_W(8), .LSB_FIRST(1'b0)) dutB (
        .RxClkEsc (clk),
        .RST      (RST),
        .escIf    (busB)
    );

    assign busB.EscDeserEn = busA.EscDeserEn;
    assign busB.EscBit     = busA.EscBit;
    assign busB.RxLpdtEsc  = busA.RxLpdtEsc;
    assign busB.LpFsmStop  = busA.LpFsmStop;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (busA.RxValidEsc === 1'b1) begin
            validCnt     = validCnt + 1;
            prevValidCyc = lastValidCyc;
            lastValidCyc = cyc;
        end
        if (busA.RxPartialEsc === 1'b1) partialCnt = partialCnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            errors = errors + 1;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic sendBit(input logic b, input logic stop);
        busA.EscDeserEn = 1'b1;
        busA.RxLpdtEsc  = 1'b1;
        busA.EscBit     = b;
        busA.LpFsmStop  = stop;
        @(posedge clk);
        #1;
    endtask

    task automatic endBurst();
        busA.EscDeserEn = 1'b0;
        busA.EscBit     = 1'b0;
        busA.LpFsmStop  = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic idleCycle();
        busA.EscDeserEn = 1'b0;
        busA.EscBit     = 1'b0;
        busA.LpFsmStop  = 1'b0;
        busA.RxLpdtEsc  = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0]  p8;
        logic [15:0] p16;
        logic [10:0] p11;

        busA.EscDeserEn = 1'b0;
        busA.EscBit     = 1'b0;
        busA.RxLpdtEsc  = 1'b0;
        busA.LpFsmStop  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_data",    32'(busA.RxDataEsc),    32'h0);
        check("rst_valid",   32'(busA.RxValidEsc),   32'h0);
        check("rst_partial", 32'(busA.RxPartialEsc), 32'h0);
        check("rst_active",  32'(busA.RxActiveEsc),  32'h0);
`ifdef ESC_DESER_BYTECNT_EN
        check("rst_bytecnt", 32'(busA.RxByteCntEsc), 32'h0);
`endif
        RST = 1'b0;
        idleCycle();

        // Bits offered without LPDT mode must be ignored.
        busA.EscDeserEn = 1'b1;
        busA.EscBit     = 1'b1;
        @(posedge clk);
        #1;
        check("no_lpdt_active", 32'(busA.RxActiveEsc), 32'h0);
        idleCycle();

        // 8'hA5 burst
        vSnap = validCnt;
        pSnap = partialCnt;
        p8 = 8'hA5;
        for (int i = 0; i < 8; i++) begin
            sendBit(p8[i], 1'b0);
            if (i == 0) check("a5_active_rise", 32'(busA.RxActiveEsc), 32'h1);
        end
        check("a5_valid",  32'(busA.RxValidEsc), 32'h1);
        check("a5_data",   32'(busA.RxDataEsc),  32'hA5);
        check("a5_data_msbfirst", 32'(busB.RxDataEsc), 32'hA5);
        endBurst();
        check("a5_partial", 32'(busA.RxPartialEsc), 32'h0);
        check("a5_active_fall", 32'(busA.RxActiveEsc), 32'h0);
        check("a5_valid_drop", 32'(busA.RxValidEsc), 32'h0);
        idleCycle();
        check("a5_valid_count", 32'(validCnt - vSnap), 32'h1);
        check("a5_partial_count", 32'(partialCnt - pSnap), 32'h0);

        // 8'h01 stream: bit order differs between instances
        p8 = 8'h01;
        for (int i = 0; i < 8; i++) sendBit(p8[i], 1'b0);
        check("b01_lsbfirst", 32'(busA.RxDataEsc), 32'h01);
        check("b01_msbfirst", 32'(busB.RxDataEsc), 32'h80);
        endBurst();
        idleCycle();

        // Back-to-back 8'h12, 8'h34
        p16 = 16'h3412;
        for (int i = 0; i < 16; i++) begin
            sendBit(p16[i], 1'b0);
            if (i == 7) check("b2b_first", 32'(busA.RxDataEsc), 32'h12);
            if (i == 15) check("b2b_second", 32'(busA.RxDataEsc), 32'h34);
        end
        endBurst();
        check("b2b_spacing", 32'(lastValidCyc - prevValidCyc), 32'd8);
`ifdef ESC_DESER_BYTECNT_EN
        check("b2b_bytecnt", 32'(busA.RxByteCntEsc), 32'd2);
`endif
        idleCycle();
        check("b2b_data_held", 32'(busA.RxDataEsc), 32'h34);

        // 11 bits: one byte 8'hC3 plus 3 leftover ones
        pSnap = partialCnt;
        p11 = 11'h7C3;
        for (int i = 0; i < 11; i++) begin
            sendBit(p11[i], 1'b0);
            if (i == 7) check("b11_byte", 32'(busA.RxDataEsc), 32'hC3);
        end
        endBurst();
        check("b11_partial", 32'(busA.RxPartialEsc), 32'h1);
        check("b11_active", 32'(busA.RxActiveEsc), 32'h0);
        idleCycle();
        check("b11_partial_pulse", 32'(busA.RxPartialEsc), 32'h0);
        check("b11_leftover_hidden", 32'(busA.RxDataEsc), 32'hC3);
        check("b11_partial_count", 32'(partialCnt - pSnap), 32'h1);

        // Eighth bit coincident with stop
        pSnap = partialCnt;
        p8 = 8'h5A;
        for (int i = 0; i < 8; i++) sendBit(p8[i], i == 7);
        check("stop8_valid", 32'(busA.RxValidEsc), 32'h1);
        check("stop8_data", 32'(busA.RxDataEsc), 32'h5A);
        check("stop8_partial", 32'(busA.RxPartialEsc), 32'h0);
        check("stop8_active", 32'(busA.RxActiveEsc), 32'h0);
        idleCycle();
        check("stop8_partial_count", 32'(partialCnt - pSnap), 32'h0);

        // Async reset after 5 bits, then a clean burst
        for (int i = 0; i < 5; i++) sendBit(1'b1, 1'b0);
        RST = 1'b1;
        #1;
        check("mid_rst_data", 32'(busA.RxDataEsc), 32'h0);
        check("mid_rst_active", 32'(busA.RxActiveEsc), 32'h0);
        check("mid_rst_valid", 32'(busA.RxValidEsc), 32'h0);
        check("mid_rst_partial", 32'(busA.RxPartialEsc), 32'h0);
        pSnap = partialCnt;
        busA.EscDeserEn = 1'b0;
        busA.LpFsmStop  = 1'b0;
        @(posedge clk);
        #1;
        RST = 1'b0;
        idleCycle();
        p8 = 8'h96;
        for (int i = 0; i < 8; i++) sendBit(p8[i], i == 7);
        check("post_rst_valid", 32'(busA.RxValidEsc), 32'h1);
        check("post_rst_data", 32'(busA.RxDataEsc), 32'h96);
`ifdef ESC_DESER_BYTECNT_EN
        check("post_rst_bytecnt", 32'(busA.RxByteCntEsc), 32'd1);
`endif
        idleCycle();
        check("post_rst_no_partial", 32'(partialCnt - pSnap), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/esc_deserializer.md
# esc_deserializer

Escape-mode LPDT byte assembler sitting directly downstream of the escape decoder on the receive side, clocked by RxClkEsc. Consumes the serial LPDT bit stream (EscBit qualified by EscDeserEn) and stop indications, packs bits into bytes, presents each byte with a one-cycle valid strobe, and flags bursts that end on a non-byte boundary.

## Interface
- BYTE_W, 8, bits per assembled word
- LSB_FIRST, 1, 1: first received bit lands in RxDataEsc[0]; 0: first bit lands in RxDataEsc[BYTE_W-1]

- RxClkEsc  input  1  escape clock; all logic on posedge
- RST  input  1  asynchronous, active-high reset
- EscDeserEn  input  1  bit-valid qualifier from decoder
- EscBit  input  1  serial data bit, valid when EscDeserEn=1
- RxLpdtEsc  input  1  LPDT mode active; bits accepted only when 1
- LpFsmStop  input  1  stop state detected; terminates burst
- RxDataEsc  output  BYTE_W  assembled byte, held until next byte completes
- RxValidEsc  output  1  one-cycle strobe, RxDataEsc new this cycle
- RxPartialEsc  output  1  one-cycle strobe, burst ended with 1..BYTE_W-1 leftover bits
- RxActiveEsc  output  1  high while in SHIFT state

## Operation
- accept = EscDeserEn & RxLpdtEsc.
- States: IDLE, SHIFT, FLUSH. Reset -> IDLE.
- IDLE: bit count 0, shift register 0. accept=1 -> capture bit, count=1, go SHIFT.
- SHIFT: each accept=1 edge shifts EscBit in (direction per LSB_FIRST), count+1. At count=BYTE_W-1 with accept=1: RxDataEsc <= completed word, RxValidEsc=1, count wraps to 0, stay SHIFT.
- SHIFT exit: LpFsmStop=1, or accept=0 -> FLUSH. accept=0 cycles with LpFsmStop=0 while RxLpdtEsc=1 are not gaps; decoder never gaps mid-burst, so accept=0 is treated as burst end.
- FLUSH (one cycle): if count!=0, RxPartialEsc=1; leftover bits discarded, never output. Clear count/shift register; go IDLE.
- Simultaneous accept=1 and LpFsmStop=1 on same edge: bit is accepted first (may complete a byte -> RxValidEsc); then transition to FLUSH with post-accept count.
- RxLpdtEsc falling while in SHIFT is handled as burst end (accept=0).
- RxDataEsc never changes except on a byte completion or reset.
- Reset mid-burst: all state and outputs cleared immediately (async); no partial flag.

## Timing
- Reset values: RxDataEsc=0, RxValidEsc=0, RxPartialEsc=0, RxActiveEsc=0, state IDLE, count 0.
- All outputs registered.
- Latency: RxValidEsc and new RxDataEsc visible the cycle after the posedge sampling the BYTE_W-th bit.
- Minimum spacing of RxValidEsc: BYTE_W cycles.
- RxPartialEsc: asserted the cycle FLUSH is entered... i.e., registered at the edge leaving SHIFT; high exactly one cycle.
- RxActiveEsc: rises the cycle after first accepted bit; falls on FLUSH entry.
- Count width: clog2(BYTE_W); wraps BYTE_W-1 -> 0 without overflow.

## Configuration
- ESC_DESER_BYTECNT_EN defined: adds output RxByteCntEsc [15:0]; cleared on reset and on IDLE->SHIFT entry; increments with each RxValidEsc; saturates at 16'hFFFF; held through FLUSH/IDLE until next burst starts.
- Not defined: port and counter absent; all other behaviour identical.

## Test plan
- LSB_FIRST=1, burst bits 1,0,1,0,0,1,0,1 then LpFsmStop -> RxDataEsc=8'hA5, one RxValidEsc, RxPartialEsc stays 0.
- LSB_FIRST=0, same bits -> RxDataEsc=8'hA5 reversed order = 8'hA5 for palindrome; use 8'h3C stream (0,0,1,1,1,1,0,0 LSB-first) -> 8'h3C with LSB_FIRST=1, 8'h3C with LSB_FIRST=0 only if symmetric; bench uses 8'h01 stream (1,0,0,0,0,0,0,0) -> 8'h01 (LSB_FIRST=1) vs 8'h80 (LSB_FIRST=0).
- Two back-to-back bytes 8'h12, 8'h34 -> two RxValidEsc exactly 8 cycles apart; with ESC_DESER_BYTECNT_EN, RxByteCntEsc=2 after burst.
- 11 bits then LpFsmStop -> one byte valid, RxPartialEsc=1 for one cycle, 3 leftover bits never appear on RxDataEsc.
- 8th bit coincident with LpFsmStop=1 -> byte output, RxPartialEsc=0.
- RST asserted after 5 bits -> all outputs 0 immediately; following clean 8-bit burst decodes correctly.
